// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the byte-serial instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/imem_boot_loader_timeout.sv
// Inactivity counter: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT_CYC-th idle cycle.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en)    cnt_d = '0;
    else if (!expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: assembles big-endian words, writes them into
// instruction memory, checks an XOR checksum and holds the CPU while loading.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int         ROM_SIZE    = 128,
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int NW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [1:0]        err_sel;
  logic [23:0]       shift_q, shift_d;   // three earlier bytes of the current word
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     words_q, words_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_err_q, load_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic rx_fire, is_start, len_bad, to_exp, to_en;

  // Held low during reset so no byte is ever taken while the loader is cleared.
  assign rx_ready = reset && (state_q != S_WRITE);
  assign rx_fire  = rx_valid && rx_ready;
  assign is_start = rx_data == START_BYTE;
  assign len_bad  = (rx_data == 8'd0) || (int'(rx_data) > ROM_SIZE);
  assign to_en    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_fire),
    .en      (to_en),
    .expired (to_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A received byte takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    err_sel = ERR_NONE;
    case (state_q)
      S_IDLE:  if (rx_fire && is_start) state_d = S_LEN;
      S_LEN: begin
        if (rx_fire) begin
          if (len_bad) begin state_d = S_ERROR; err_sel = ERR_LEN; end
          else           state_d = S_DATA;
        end else if (to_exp) begin
          state_d = S_ERROR; err_sel = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end else if (to_exp) begin
          state_d = S_ERROR; err_sel = ERR_TIMEOUT;
        end
      end
      S_WRITE: state_d = (words_q + 1'b1 == n_q) ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (rx_fire) begin
          if (rx_data == csum_q) state_d = S_DONE;
          else begin state_d = S_ERROR; err_sel = ERR_CSUM; end
        end else if (to_exp) begin
          state_d = S_ERROR; err_sel = ERR_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: if (rx_fire && is_start) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    csum_d      = csum_q;
    byte_cnt_d  = byte_cnt_q;
    n_d         = n_q;
    words_d     = words_q;
    cpu_hold_d  = cpu_hold_q;
    load_err_d  = load_err_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (rx_fire && is_start) begin
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
          err_code_d = ERR_NONE;
          csum_d     = '0;
          words_d    = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN: begin
        if (rx_fire && !len_bad) begin
          n_d        = NW'(rx_data);
          byte_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          shift_d    = {shift_q[15:0], rx_data};
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          // Write port is registered, so it is loaded here and strobes during WRITE.
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = words_q[ADDR_W-1:0];
            mem_wdata_d = {shift_q, rx_data};
          end
        end
      end
      S_WRITE: words_d = words_q + 1'b1;
      S_DONE:  cpu_hold_d = 1'b0;
      default: ;
    endcase
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      load_err_d = 1'b1;
      err_code_d = err_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      csum_q      <= '0;
      byte_cnt_q  <= '0;
      n_q         <= '0;
      words_q     <= '0;
      cpu_hold_q  <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      byte_cnt_q  <= byte_cnt_d;
      n_q         <= n_d;
      words_q     <= words_d;
      cpu_hold_q  <= cpu_hold_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = state_q == S_DONE;
  assign load_err     = load_err_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes and done pulses are
// queued by the stimulus and consumed by a negedge monitor.
module tb_imem_boot_loader;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, cpu_hold, load_done, load_err;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [7:0]  words_loaded;

  imem_boot_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done = 0;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [31:0] d);
    exp_wr.push_back(wr_t'({a, d}));
  endtask

  // Hold the byte until it is taken; rx_ready is sampled at negedge, stable until posedge.
  task automatic send(input logic [7:0] b);
    logic rdy;
    int   n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      rdy      = rx_ready;
      @(posedge clk);
      n++;
      if (!rdy && n > 8) begin
        tests++;
        fails++;
        $display("FAIL rx_accept: byte %h not taken within 8 cycles", b);
        break;
      end
    end
    #1 rx_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      if (mem_we) begin
        check("we_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("we_addr", 32'(mem_addr), 32'(e.a));
          check("we_data", mem_wdata, e.d);
        end
      end
      if (load_done) begin
        check("done_expected", 32'(exp_done > 0), 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b, cs;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_rx_ready", rx_ready, 0);
    rst_n = 1'b1;

    // 1: single word
    send(8'hA5);
    @(negedge clk);
    check("t1_hold_on", cpu_hold, 1);
    send(8'h01);
    push_wr(7'd0, 32'h12345678);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    exp_done++;
    send(8'h08);
    @(negedge clk);
    check("t1_done", load_done, 1);
    check("t1_hold_in_done", cpu_hold, 1);
    @(negedge clk);
    check("t1_hold_off", cpu_hold, 0);
    check("t1_words", 32'(words_loaded), 1);
    check("t1_wdata_held", mem_wdata, 32'h12345678);
    check("t1_err", load_err, 0);

    // 2: full memory, back-to-back bytes (stalled during each WRITE)
    send(8'hA5);
    send(8'h80);
    w = 0; cs = 0;
    for (int i = 0; i < 512; i++) begin
      b  = 8'((i * 7) + 3);
      w  = {w[23:0], b};
      cs = cs ^ b;
      if (i % 4 == 3) push_wr(7'(i / 4), w);
      send(b);
    end
    exp_done++;
    send(cs);
    @(negedge clk);
    check("t2_done", load_done, 1);
    check("t2_words", 32'(words_loaded), 128);
    check("t2_last_addr", 32'(mem_addr), 127);
    @(negedge clk);
    check("t2_hold_off", cpu_hold, 0);

    // 3: bad checksum (correct would be 88)
    send(8'hA5); send(8'h02);
    push_wr(7'd0, 32'h11223344);
    push_wr(7'd1, 32'h55667788);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(8'h00);
    repeat (3) @(negedge clk);
    check("t3_err", load_err, 1);
    check("t3_code", 32'(err_code), 2);
    check("t3_hold", cpu_hold, 1);
    check("t3_words", 32'(words_loaded), 2);

    // 4: bad lengths, then recovery
    send(8'hA5); send(8'h00);
    @(negedge clk);
    check("t4_len0_err", load_err, 1);
    check("t4_len0_code", 32'(err_code), 1);
    send(8'hA5);
    @(negedge clk);
    check("t4_restart_clr", load_err, 0);
    check("t4_restart_code", 32'(err_code), 0);
    send(8'h81);
    @(negedge clk);
    check("t4_len81_code", 32'(err_code), 1);
    check("t4_len81_hold", cpu_hold, 1);
    send(8'hA5); send(8'h01);
    push_wr(7'd0, 32'hDEADBEEF);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    exp_done++;
    send(8'h22);
    @(negedge clk);
    check("t4_done", load_done, 1);
    @(negedge clk);
    check("t4_err_clr", load_err, 0);
    check("t4_code_clr", 32'(err_code), 0);
    check("t4_hold_off", cpu_hold, 0);

    // 5: timeout mid-word
    send(8'hA5); send(8'h01); send(8'h12);
    repeat (TO - 4) @(negedge clk);
    check("t5_no_early_to", 32'(err_code), 0);
    repeat (8) @(negedge clk);
    check("t5_to_code", 32'(err_code), 3);
    check("t5_to_err", load_err, 1);
    check("t5_to_hold", cpu_hold, 1);

    // 6: reset mid-DATA, then a fresh frame
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
    @(negedge clk);
    check("t6_pre_hold", cpu_hold, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hold", cpu_hold, 0);
    check("t6_rst_err", load_err, 0);
    check("t6_rst_code", 32'(err_code), 0);
    check("t6_rst_words", 32'(words_loaded), 0);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hA5); send(8'h01);
    push_wr(7'd0, 32'hCAFEBABE);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    exp_done++;
    send(8'h30);
    @(negedge clk);
    check("t6_done", load_done, 1);
    check("t6_words", 32'(words_loaded), 1);

    repeat (3) @(negedge clk);
    check("sb_writes_drained", 32'(exp_wr.size()), 0);
    check("sb_done_drained", 32'(exp_done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
